eth_tx_framer: RTL and testbench

Per-lane transmit framer, the egress counterpart of the per-lane FCS check. It takes a frame's payload bytes (dst MAC through last data byte) from the crossbar egress queue and drives one 8-bit TXD/TXC lane of the switchcore. It prepends preamble and SFD, pads short frames, appends a CRC-32 FCS and enforces the inter-frame gap. Four instances sit between the crossbar queues and tx_data/tx_ctrl.

---
 rtl/eth_tx_pkg.sv | 34 +++
 rtl/eth_tx_framer_if.sv | 10 +
 rtl/eth_tx_framer_crc32_gen.sv | 25 ++
 rtl/eth_tx_framer.sv | 177 +++++++++++++++++
 tb/tb_eth_tx_framer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and CRC-32 helper for the per-lane Ethernet transmit path.
// The CRC helper is byte-at-a-time, reflected (LSB first), matching IEEE 802.3 FCS.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        DRAIN
    } state_t;

    localparam logic [7:0]  C_PREAMBLE = 8'h55;
    localparam logic [7:0]  C_SFD      = 8'hD5;
    localparam logic [31:0] C_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] C_CRC_INIT = 32'hFFFFFFFF;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ C_CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload byte stream from a crossbar egress queue into one transmit framer.
interface eth_tx_framer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer_crc32_gen.sv
// Registered CRC-32 accumulator; init has priority over en. Shared with the FCS checker.
module crc32_gen
    import eth_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    logic [31:0] crc_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crc_reg <= C_CRC_INIT;
        end else if (init) begin
            crc_reg <= C_CRC_INIT;
        end else if (en) begin
            crc_reg <= crc32_byte(crc_reg, data);
        end
    end

    assign crc = crc_reg;
endmodule

// File: rtl/eth_tx_framer.sv
// Per-lane transmit framer: preamble/SFD, payload, zero padding, FCS and inter-frame gap.
// Lane outputs are registered, so each state decides what the lane shows one cycle later.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int P_MIN_LEN = 60,
    parameter int P_PAD_EN  = 1,
    parameter int P_IFG     = 12
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             link_i,
    eth_tx_framer_if.slave   s,
    output logic [7:0]       tx_data_o,
    output logic             tx_ctrl_o,
    output logic             busy_o,
    output logic             underrun_o,
    output logic [15:0]      frame_cnt_o
);
    localparam logic [11:0] C_MIN_LEN  = 12'(P_MIN_LEN);
    localparam logic [7:0]  C_IFG_LAST = 8'(P_IFG - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [10:0] byte_cnt_reg, byte_cnt_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_ctrl_reg, tx_ctrl_next;
    logic        underrun_reg, underrun_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;

    logic        crc_init, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc;
    logic [31:0] fcs_word;
    logic [11:0] byte_cnt_inc;
    logic        s_ready;

    crc32_gen u_crc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .init   (crc_init),
        .en     (crc_en),
        .data   (crc_data),
        .crc    (crc)
    );

    assign s_ready      = (state_reg == DATA) || (state_reg == DRAIN);
    assign s.s_ready    = s_ready;
    assign fcs_word     = ~crc;
    assign byte_cnt_inc = {1'b0, byte_cnt_reg} + 12'd1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            byte_cnt_reg  <= '0;
            tx_data_reg   <= '0;
            tx_ctrl_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            tx_data_reg   <= tx_data_next;
            tx_ctrl_reg   <= tx_ctrl_next;
            underrun_reg  <= underrun_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        tx_data_next   = 8'h00;
        tx_ctrl_next   = 1'b0;
        underrun_next  = 1'b0;
        frame_cnt_next = frame_cnt_reg;
        crc_init       = 1'b0;
        crc_en         = 1'b0;
        crc_data       = s.s_data;

        case (state_reg)
            IDLE: begin
                if (s.s_valid && link_i) begin
                    state_next    = PREAMBLE;
                    cnt_next      = '0;
                    byte_cnt_next = '0;
                    crc_init      = 1'b1;
                    tx_ctrl_next  = 1'b1;
                    tx_data_next  = C_PREAMBLE;
                end
            end
            // The IDLE decision already put the first 0x55 out, so six more here.
            PREAMBLE: begin
                tx_ctrl_next = 1'b1;
                tx_data_next = C_PREAMBLE;
                cnt_next     = cnt_reg + 8'd1;
                if (cnt_reg == 8'd5) begin
                    state_next = SFD;
                end
            end
            SFD: begin
                tx_ctrl_next = 1'b1;
                tx_data_next = C_SFD;
                state_next   = DATA;
            end
            DATA: begin
                if (s.s_valid) begin
                    tx_ctrl_next = 1'b1;
                    tx_data_next = s.s_data;
                    crc_en       = 1'b1;
                    if (byte_cnt_reg != 11'h7FF) begin
                        byte_cnt_next = byte_cnt_reg + 11'd1;
                    end
                    if (s.s_last) begin
                        cnt_next = '0;
                        if ((P_PAD_EN != 0) && (byte_cnt_inc < C_MIN_LEN)) begin
                            state_next = PAD;
                        end else begin
                            state_next = FCS;
                        end
                    end
                end else begin
                    underrun_next = 1'b1;
                    state_next    = DRAIN;
                end
            end
            PAD: begin
                tx_ctrl_next  = 1'b1;
                crc_en        = 1'b1;
                crc_data      = 8'h00;
                byte_cnt_next = byte_cnt_reg + 11'd1;
                if (byte_cnt_inc >= C_MIN_LEN) begin
                    state_next = FCS;
                    cnt_next   = '0;
                end
            end
            FCS: begin
                tx_ctrl_next = 1'b1;
                cnt_next     = cnt_reg + 8'd1;
                case (cnt_reg[1:0])
                    2'd0:    tx_data_next = fcs_word[7:0];
                    2'd1:    tx_data_next = fcs_word[15:8];
                    2'd2:    tx_data_next = fcs_word[23:16];
                    default: tx_data_next = fcs_word[31:24];
                endcase
                if (cnt_reg[1:0] == 2'd3) begin
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    state_next     = IFG;
                    cnt_next       = '0;
                end
            end
            // P_IFG cycles here plus the IDLE decision cycle give P_IFG low lane cycles.
            IFG: begin
                cnt_next = cnt_reg + 8'd1;
                if (cnt_reg == C_IFG_LAST) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (s.s_valid && s.s_last) begin
                    state_next = IFG;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_data_o   = tx_data_reg;
    assign tx_ctrl_o   = tx_ctrl_reg;
    assign underrun_o  = underrun_reg;
    assign frame_cnt_o = frame_cnt_reg;
    assign busy_o      = (state_reg != IDLE);
endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench: expected lane bytes are queued when a frame is driven and checked as they appear.
module tb_eth_tx_framer;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rstn;
    logic       link;
    logic       s_valid [2];
    logic       s_last  [2];
    logic [7:0] s_data  [2];
    logic       s_ready [2];
    logic [7:0] tx_data [2];
    logic       tx_ctrl [2];
    logic       busy    [2];
    logic       underrun[2];
    logic [15:0] frame_cnt[2];

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[2][$];
    int   hi_cnt[2];
    int   last_hi[2];
    int   lo_cnt[2];
    int   last_gap[2];
    int   ur_cnt[2];
    logic prev_ctrl[2];

    always #5 clk = ~clk;

    eth_tx_framer_if s_if0();
    eth_tx_framer_if s_if1();

    assign s_if0.s_valid = s_valid[0];
    assign s_if0.s_data  = s_data[0];
    assign s_if0.s_last  = s_last[0];
    assign s_ready[0]    = s_if0.s_ready;
    assign s_if1.s_valid = s_valid[1];
    assign s_if1.s_data  = s_data[1];
    assign s_if1.s_last  = s_last[1];
    assign s_ready[1]    = s_if1.s_ready;

    eth_tx_framer #(.P_MIN_LEN(60), .P_PAD_EN(1), .P_IFG(12)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .link_i(link), .s(s_if0),
        .tx_data_o(tx_data[0]), .tx_ctrl_o(tx_ctrl[0]), .busy_o(busy[0]),
        .underrun_o(underrun[0]), .frame_cnt_o(frame_cnt[0])
    );

    eth_tx_framer #(.P_MIN_LEN(60), .P_PAD_EN(0), .P_IFG(12)) u_dut_nopad (
        .clk_i(clk), .rstn_i(rstn), .link_i(link), .s(s_if1),
        .tx_data_o(tx_data[1]), .tx_ctrl_o(tx_ctrl[1]), .busy_o(busy[1]),
        .underrun_o(underrun[1]), .frame_cnt_o(frame_cnt[1])
    );

    // Lane monitor: every tx_ctrl-high byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_ctrl[d] === 1'b1) begin
                if (prev_ctrl[d] !== 1'b1) last_gap[d] = lo_cnt[d];
                hi_cnt[d]++;
                tests_run++;
                if (exp_q[d].size() == 0) begin
                    tests_failed++;
                    $display("FAIL lane_extra dut%0d got %02h required no byte", d, tx_data[d]);
                end else begin
                    logic [7:0] e;
                    e = exp_q[d].pop_front();
                    if (tx_data[d] !== e) begin
                        tests_failed++;
                        $display("FAIL lane_byte dut%0d got %02h required %02h", d, tx_data[d], e);
                    end
                end
            end else begin
                if (prev_ctrl[d] === 1'b1) begin
                    last_hi[d] = hi_cnt[d];
                    hi_cnt[d]  = 0;
                    lo_cnt[d]  = 0;
                end
                lo_cnt[d]++;
            end
            if (underrun[d] === 1'b1) ur_cnt[d]++;
            prev_ctrl[d] = tx_ctrl[d];
        end
    end

    function automatic logic [31:0] ref_fcs(input bq_t fr);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            c ^= {24'h0, fr[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t mk_payload(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic push_frame(input int d, input bq_t pl, input bit pad);
        bq_t fr;
        logic [31:0] c;
        fr = pl;
        if (pad) while (fr.size() < 60) fr.push_back(8'h00);
        c = ref_fcs(fr);
        repeat (7) exp_q[d].push_back(8'h55);
        exp_q[d].push_back(8'hD5);
        foreach (fr[i]) exp_q[d].push_back(fr[i]);
        for (int k = 0; k < 4; k++) exp_q[d].push_back(c[8*k +: 8]);
    endtask

    task automatic send(input int d, input bq_t pl, input bit with_last);
        int i = 0;
        int guard = 0;
        logic hs;
        s_valid[d] = 1'b1;
        s_data[d]  = pl[0];
        s_last[d]  = with_last && (pl.size() == 1);
        while (i < pl.size() && guard < 5000) begin
            @(negedge clk);
            hs = s_ready[d];
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                i++;
                if (i < pl.size()) begin
                    s_data[d] = pl[i];
                    s_last[d] = with_last && (i == pl.size() - 1);
                end
            end
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
        tests_run++;
        if (i != pl.size()) begin
            tests_failed++;
            $display("FAIL send_timeout dut%0d got %0d bytes accepted required %0d", d, i, pl.size());
        end
    endtask

    task automatic wait_idle(input int d);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy[d] || tx_ctrl[d]) && g < 3000);
        tests_run++;
        if (busy[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_timeout dut%0d got busy=%b required 0", d, busy[d]);
        end
    endtask

    task automatic check_done(input int d, input int fc, input string tag);
        tests_run++;
        if (frame_cnt[d] !== 16'(fc)) begin
            tests_failed++;
            $display("FAIL %s_frame_cnt got %0d required %0d", tag, frame_cnt[d], fc);
        end
        tests_run++;
        if (exp_q[d].size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing got %0d bytes left required 0", tag, exp_q[d].size());
        end
    endtask

    task automatic test_reset();
        logic [27:0] got;
        rstn = 1'b0;
        link = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_last[d]  = 1'b0;
            s_data[d]  = 8'h00;
        end
        #12;
        got = {tx_ctrl[0], tx_data[0], busy[0], underrun[0], frame_cnt[0], s_ready[0]};
        tests_run++;
        if (got !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_state got %07h required 0000000", got);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_nopad_known_fcs();
        bq_t pl;
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        repeat (7) exp_q[1].push_back(8'h55);
        exp_q[1].push_back(8'hD5);
        foreach (pl[i]) exp_q[1].push_back(pl[i]);
        exp_q[1].push_back(8'h26); exp_q[1].push_back(8'h39);
        exp_q[1].push_back(8'hF4); exp_q[1].push_back(8'hCB);
        send(1, pl, 1'b1);
        wait_idle(1);
        tests_run++;
        if (last_hi[1] != 21) begin
            tests_failed++;
            $display("FAIL nopad_ctrl_len got %0d required 21", last_hi[1]);
        end
        check_done(1, 1, "nopad");
        $display("[TB] frame 123456789 without padding");
    endtask

    task automatic test_pad();
        bq_t pl = mk_payload(14);
        push_frame(0, pl, 1'b1);
        send(0, pl, 1'b1);
        wait_idle(0);
        tests_run++;
        if (last_hi[0] != 72) begin
            tests_failed++;
            $display("FAIL pad_ctrl_len got %0d required 72", last_hi[0]);
        end
        check_done(0, 1, "pad");
        $display("[TB] 14-byte frame padded to 60");
    endtask

    task automatic test_back_to_back();
        bq_t f1 = mk_payload(64);
        bq_t f2 = mk_payload(64);
        push_frame(0, f1, 1'b1);
        push_frame(0, f2, 1'b1);
        send(0, f1, 1'b1);
        send(0, f2, 1'b1);
        wait_idle(0);
        tests_run++;
        if (last_gap[0] != 12) begin
            tests_failed++;
            $display("FAIL ifg_gap got %0d required 12", last_gap[0]);
        end
        tests_run++;
        if (last_hi[0] != 76) begin
            tests_failed++;
            $display("FAIL b2b_ctrl_len got %0d required 76", last_hi[0]);
        end
        check_done(0, 3, "b2b");
        $display("[TB] two back-to-back 64-byte frames");
    endtask

    task automatic test_underrun();
        bq_t pl = mk_payload(64);
        bq_t head, tail, nxt;
        int  ur0 = ur_cnt[0];
        for (int i = 0; i < 64; i++) begin
            if (i < 20) head.push_back(pl[i]);
            else        tail.push_back(pl[i]);
        end
        repeat (7) exp_q[0].push_back(8'h55);
        exp_q[0].push_back(8'hD5);
        foreach (head[i]) exp_q[0].push_back(head[i]);
        send(0, head, 1'b0);
        @(posedge clk);
        #1;
        tests_run++;
        if (tx_ctrl[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL underrun_ctrl got %b required 0", tx_ctrl[0]);
        end
        tests_run++;
        if (underrun[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL underrun_pulse got %b required 1", underrun[0]);
        end
        send(0, tail, 1'b1);
        wait_idle(0);
        tests_run++;
        if (ur_cnt[0] - ur0 != 1) begin
            tests_failed++;
            $display("FAIL underrun_count got %0d required 1", ur_cnt[0] - ur0);
        end
        check_done(0, 3, "underrun");
        nxt = mk_payload(30);
        push_frame(0, nxt, 1'b1);
        send(0, nxt, 1'b1);
        wait_idle(0);
        check_done(0, 4, "after_underrun");
        $display("[TB] underrun after byte 20, drained, next frame sent");
    endtask

    task automatic test_link();
        bq_t pl = mk_payload(20);
        int  bad = 0;
        link = 1'b0;
        push_frame(0, pl, 1'b1);
        s_valid[0] = 1'b1;
        s_data[0]  = pl[0];
        s_last[0]  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_ctrl[0] !== 1'b0 || s_ready[0] !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL link_hold got %0d active cycles required 0", bad);
        end
        @(posedge clk);
        #1 link = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({tx_ctrl[0], tx_data[0]} !== 9'h155) begin
            tests_failed++;
            $display("FAIL link_start got %b/%02h required 1/55", tx_ctrl[0], tx_data[0]);
        end
        send(0, pl, 1'b1);
        wait_idle(0);
        check_done(0, 5, "link");
        $display("[TB] link gating then frame");
    endtask

    task automatic test_reset_mid_frame();
        bq_t pl = mk_payload(10);
        bq_t nxt;
        logic [9:0] got;
        push_frame(0, pl, 1'b1);
        send(0, pl, 1'b1);
        repeat (51) @(posedge clk);
        #2;
        tests_run++;
        if (tx_ctrl[0] !== 1'b1 || busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_active got ctrl=%b busy=%b required 1/1", tx_ctrl[0], busy[0]);
        end
        rstn = 1'b0;
        #1;
        got = {tx_ctrl[0], tx_data[0], busy[0]};
        tests_run++;
        if (got !== 10'h0) begin
            tests_failed++;
            $display("FAIL async_reset_lane got %03h required 000", got);
        end
        tests_run++;
        if (frame_cnt[0] !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_reset_cnt got %0d required 0", frame_cnt[0]);
        end
        exp_q[0].delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        nxt = mk_payload(60);
        push_frame(0, nxt, 1'b1);
        send(0, nxt, 1'b1);
        wait_idle(0);
        tests_run++;
        if (last_hi[0] != 72) begin
            tests_failed++;
            $display("FAIL post_reset_ctrl_len got %0d required 72", last_hi[0]);
        end
        check_done(0, 1, "post_reset");
        $display("[TB] async reset during FCS, clean restart");
    endtask

    initial begin
        test_reset();
        test_nopad_known_fcs();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_link();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no completion required finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
